// File: rtl/demux_pkg.sv
// Shared constants and lock-state encoding for the 1-to-4 stream demultiplexer.
package demux_pkg;

  localparam int NUM_OUT = 4;
  localparam int SEL_W   = 2;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } lock_state_t;

endpackage

// File: rtl/demux_slot.sv
// One-entry output holding register: load writes a beat, drain empties it,
// load and drain together replace the beat so a ready sink sees one per cycle.
module demux_slot #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              drain,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_last,
  output logic              valid,
  output logic [DATA_W-1:0] data,
  output logic              last
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= '0;
      last  <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= load_data;
      last  <= load_last;
    end else if (drain) begin
      // Data and last are left as-is; they are don't-care while valid is low.
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/stream_demux_1_4.sv
// Packet-aware 1-to-4 stream demultiplexer. The route is taken from in_sel on
// the first beat of a packet and locked until the beat carrying in_last.
//
// Handshake: a beat moves across any valid/ready pair on the rising clk edge
// where both are high; valid never waits on ready, and once a port raises
// out_valid its data and last hold until out_ready is seen high.
module stream_demux_1_4
  import demux_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DATA_W-1:0]         in_data,
  input  logic [SEL_W-1:0]          in_sel,
  input  logic                      in_last,
  output logic [NUM_OUT-1:0]        out_valid,
  input  logic [NUM_OUT-1:0]        out_ready,
  output logic [NUM_OUT*DATA_W-1:0] out_data,
  output logic [NUM_OUT-1:0]        out_last,
  output logic                      busy
);

  lock_state_t        state_q, state_d;
  logic [SEL_W-1:0]   lock_sel_q, lock_sel_d;
  logic [SEL_W-1:0]   route;
  logic               accept;
  logic [NUM_OUT-1:0] load;
  logic [NUM_OUT-1:0] drain;

  // in_sel only matters while no packet is in flight.
  assign route    = (state_q == LOCKED) ? lock_sel_q : in_sel;
  assign in_ready = !rst && (!out_valid[route] || out_ready[route]);
  assign accept   = in_valid && in_ready;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      lock_sel_q <= '0;
    end else begin
      state_q    <= state_d;
      lock_sel_q <= lock_sel_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d    = state_q;
    lock_sel_d = lock_sel_q;
    case (state_q)
      IDLE: begin
        if (accept && !in_last) begin
          state_d    = LOCKED;
          lock_sel_d = route;
        end
      end
      LOCKED: begin
        if (accept && in_last) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output logic.
  always_comb begin
    busy = (state_q == LOCKED);
    load = '0;
    if (accept) begin
      load[route] = 1'b1;
    end
    drain = out_valid & out_ready;
  end

  for (genvar i = 0; i < NUM_OUT; i++) begin : g_slot
    demux_slot #(
      .DATA_W(DATA_W)
    ) u_slot (
      .clk      (clk),
      .rst      (rst),
      .load     (load[i]),
      .drain    (drain[i]),
      .load_data(in_data),
      .load_last(in_last),
      .valid    (out_valid[i]),
      .data     (out_data[i*DATA_W +: DATA_W]),
      .last     (out_last[i])
    );
  end

endmodule

// File: tb/tb_stream_demux_1_4.sv
// Directed bench for stream_demux_1_4: per-port expected queues filled at
// accept time, drained by a monitor on every output transfer.
module tb_stream_demux_1_4;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic [1:0]  in_sel;
  logic        in_last;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready;
  logic [31:0] out_data;
  logic [3:0]  out_last;
  logic        busy;

  int n_cmp  = 0;
  int n_fail = 0;
  int stalls;

  logic [8:0] exp_q0[$];
  logic [8:0] exp_q1[$];
  logic [8:0] exp_q2[$];
  logic [8:0] exp_q3[$];

  stream_demux_1_4 #(.DATA_W(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_sel   (in_sel),
    .in_last  (in_last),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_last (out_last),
    .busy     (busy)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void push_exp(input int p, input logic [8:0] v);
    case (p)
      0: exp_q0.push_back(v);
      1: exp_q1.push_back(v);
      2: exp_q2.push_back(v);
      default: exp_q3.push_back(v);
    endcase
  endfunction

  function automatic int qsize(input int p);
    case (p)
      0: return exp_q0.size();
      1: return exp_q1.size();
      2: return exp_q2.size();
      default: return exp_q3.size();
    endcase
  endfunction

  function automatic logic [8:0] pop_exp(input int p);
    case (p)
      0: return exp_q0.pop_front();
      1: return exp_q1.pop_front();
      2: return exp_q2.pop_front();
      default: return exp_q3.pop_front();
    endcase
  endfunction

  function automatic void flush_exp();
    exp_q0.delete();
    exp_q1.delete();
    exp_q2.delete();
    exp_q3.delete();
  endfunction

  // Scoreboard monitor: a transfer happens at the next posedge when both are high.
  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 4; i++) begin
        if (out_valid[i] && out_ready[i]) begin
          if (qsize(i) == 0) begin
            chk($sformatf("unexpected_beat_p%0d", i), {23'd0, out_last[i], out_data[i*8 +: 8]}, 32'h1FF);
          end else begin
            chk($sformatf("beat_p%0d", i), {23'd0, out_last[i], out_data[i*8 +: 8]},
                {23'd0, pop_exp(i)});
          end
        end
      end
    end
  end

  // Driver: called just after a posedge; returns just after the accepting posedge.
  task automatic send(input logic [1:0] sel, input logic [7:0] d, input logic last,
                      input int port, input logic exp_busy, output int n_stall);
    in_valid = 1'b1;
    in_sel   = sel;
    in_data  = d;
    in_last  = last;
    n_stall  = 0;
    @(negedge clk);
    while (!in_ready && n_stall < 40) begin
      n_stall++;
      @(negedge clk);
    end
    if (!in_ready) begin
      chk("accept_timeout", 32'd0, 32'd1);
      in_valid = 1'b0;
      return;
    end
    push_exp(port, {last, d});
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("lat_valid", {31'd0, out_valid[port]}, 32'd1);
    chk("lat_data", {24'd0, out_data[port*8 +: 8]}, {24'd0, d});
    chk("busy", {31'd0, busy}, {31'd0, exp_busy});
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_sel    = '0;
    in_last   = 1'b0;
    out_ready = 4'b1111;
    #1;
    chk("rst_out_valid", {28'd0, out_valid}, 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_out_last", {28'd0, out_last}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Single-beat packets to each port on consecutive cycles.
    for (int p = 0; p < 4; p++) begin
      send(p[1:0], 8'hA0 + p[7:0], 1'b1, p, 1'b0, stalls);
      chk("single_stall", stalls, 32'd0);
    end

    // Route lock: later in_sel values are ignored.
    send(2'd2, 8'h11, 1'b0, 2, 1'b1, stalls);
    send(2'd0, 8'h22, 1'b0, 2, 1'b1, stalls);
    send(2'd0, 8'h33, 1'b1, 2, 1'b0, stalls);

    // Backpressure on port 1.
    @(posedge clk);
    #1;
    out_ready = 4'b1101;
    send(2'd1, 8'h51, 1'b0, 1, 1'b1, stalls);
    in_valid = 1'b1;
    in_sel   = 2'd3;
    in_data  = 8'h52;
    in_last  = 1'b1;
    @(negedge clk);
    chk("bp_in_ready_0", {31'd0, in_ready}, 32'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("bp_in_ready_1", {31'd0, in_ready}, 32'd0);
    chk("bp_hold_data", {24'd0, out_data[15:8]}, 32'h51);
    @(posedge clk);
    #1;
    out_ready = 4'b1111;
    @(negedge clk);
    chk("bp_release_ready", {31'd0, in_ready}, 32'd1);
    push_exp(1, {1'b1, 8'h52});
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("bp_second_valid", {31'd0, out_valid[1]}, 32'd1);
    chk("bp_second_data", {24'd0, out_data[15:8]}, 32'h52);
    chk("bp_busy", {31'd0, busy}, 32'd0);

    // Concurrent drain of ports 0 and 3.
    @(posedge clk);
    #1;
    out_ready = 4'b0110;
    send(2'd0, 8'hC0, 1'b1, 0, 1'b0, stalls);
    send(2'd3, 8'hC3, 1'b1, 3, 1'b0, stalls);
    chk("cd_both_full", {28'd0, out_valid}, 32'b1001);
    chk("cd_data0", {24'd0, out_data[7:0]}, 32'hC0);
    out_ready = 4'b1111;
    @(posedge clk);
    #1;
    chk("cd_both_empty", {28'd0, out_valid}, 32'd0);

    // Full throughput: 16-beat packet to port 1.
    for (int b = 0; b < 16; b++) begin
      send((b == 0) ? 2'd1 : 2'd2, b[7:0], (b == 15), 1, (b != 15), stalls);
      chk("tp_stall", stalls, 32'd0);
    end
    chk("tp_last", {31'd0, out_last[1]}, 32'd1);

    // Asynchronous reset mid-cycle with beats held and a packet in flight.
    @(posedge clk);
    #1;
    out_ready = 4'b0000;
    send(2'd1, 8'h61, 1'b1, 1, 1'b0, stalls);
    send(2'd3, 8'h71, 1'b0, 3, 1'b1, stalls);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_out_valid", {28'd0, out_valid}, 32'd0);
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("arst_out_data", out_data, 32'd0);
    flush_exp();
    @(negedge clk);
    rst       = 1'b0;
    out_ready = 4'b1111;
    @(posedge clk);
    #1;
    // Lock must be gone: in_sel picks the port again.
    send(2'd2, 8'h81, 1'b1, 2, 1'b0, stalls);

    repeat (3) @(posedge clk);
    #1;
    for (int p = 0; p < 4; p++) begin
      chk($sformatf("queue_empty_p%0d", p), qsize(p), 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
